bcd_uart_tx: RTL
================

# bcd_uart_tx

Formats the 8-digit packed-BCD word produced by the binary-to-BCD converter as an ASCII decimal string terminated by CR LF, and serializes it on a UART TX line, 8N1, LSB first. It sits directly downstream of the converter in the measurement-report UART path. One `start` pulse sends one frame; the block holds `busy` until the last stop bit has been sent.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. Divisor `DIV` = (CLK_FREQ + BAUD/2) / BAUD, must be ≥ 2.
- `SUPPRESS_ZEROS`, 1: 1 drops leading zero digits. 0 always sends 8 digits.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: frame request, sampled every cycle.
- `bcd`  in  32: packed BCD. `[31:28]` is the most significant digit, `[3:0]` the least.
- `busy`  out  1: high while a frame is in progress.
- `done`  out  1: one-cycle pulse when a frame completes.
- `txd`  out  1: UART serial output. Idle level is 1.

## Operation
- States: IDLE, LOAD, START, DATA, STOP, NEXT.
- **IDLE:** `start`=1 latches `bcd` into an internal register and moves to LOAD. `start` is ignored in every other state. Later changes on `bcd` do not affect a frame in flight.
- **LOAD** (1 cycle): computes the first digit index.
  - `SUPPRESS_ZEROS`=1: the index is the highest nonzero nibble. If all nibbles are zero, a single "0" is sent.
  - `SUPPRESS_ZEROS`=0: the index is 7.
  - The character count is N = digits + 2 (CR and LF).
- **Character mapping:**
  - Nibble 0–9 maps to 0x30+nibble.
  - Nibble 0xA–0xF maps to 0x3F ('?'). An invalid nibble counts as nonzero for suppression.
  - After the digits come 0x0D, then 0x0A.
- **START:** `txd`=0 for DIV cycles.
- **DATA:** 8 bits, LSB first, each held for DIV cycles.
- **STOP:** `txd`=1 for DIV cycles.
- **NEXT** (0 cycles, folded into the STOP exit): if characters remain, go to START with the next character. Otherwise return to IDLE and pulse `done`.
- The bit timer is a counter running 0..DIV-1. The bit advances when the counter reaches DIV-1. The digit index counts down and the character counter counts up. Widths are sized with `$clog2`.
- **Reset, at any time including mid-frame:**
  - Next cycle: `txd`=1, `busy`=0, `done`=0, state IDLE, counters 0.
  - No `done` is issued for the aborted frame.

## Timing
- `start` sampled at edge k: `busy`=1 from cycle k+1. LOAD occupies cycle k+1. The start bit (`txd`=0) begins at cycle k+2.
- One character = 10·DIV cycles. A frame = N·10·DIV cycles of line activity.
- At the end of the last stop bit: `busy` falls and `done`=1 in the same cycle, for exactly one cycle.
- **Back-to-back:** `start` high in the `done` cycle is accepted, because `busy` is already low. The next frame's start bit begins 2 cycles later, so the gap on the line is 2 idle cycles.
- Outputs are registered. `txd` is glitch-free.

## Structure
- **Package `bcd_uart_pkg`:**
  - state encoding constants
  - ASCII constants: ZERO=0x30, QMARK=0x3F, CR=0x0D, LF=0x0A
  - divisor function `baud_div(CLK_FREQ, BAUD)`
- **Sub-module `uart_tx_byte`:** 8N1 byte serializer with `load`/`byte`/`ready`, parameterized by DIV.
  - The top level holds the frame FSM, digit selection and character sequencing.
  - The STOP/NEXT handshake is a `ready` pulse from `uart_tx_byte`.

## Test plan
Common settings: CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10. Checks use a UART monitor sampling at mid-bit.
- **Leading-zero suppression:** `bcd`=0x0012_3450, `SUPPRESS_ZEROS`=1, pulse `start` → bytes "123450\r\n" (8 chars). `busy` lasts 1+800 cycles. One `done` pulse.
- **All zeros:** `bcd`=0x0000_0000 → bytes "0\r\n" (3 chars, 300 line cycles). With `SUPPRESS_ZEROS`=0 → "00000000\r\n".
- **Invalid nibbles:** `bcd`=0x00A0_0009 → "?00009\r\n".
- **Start handling:** `start` held high for 50 cycles mid-frame → ignored. `start` in the `done` cycle → second frame, start bit exactly 2 cycles after `done`. `bcd` changed during the frame → first frame unaffected.
- **Reset mid-frame:** `rst` asserted during the DATA bit 3 of character 2 → next cycle `txd`=1, `busy`=0, no `done`. A new `start` after reset produces a full, correct frame.
- **Bit timing:** every start, data and stop bit width is exactly 10 cycles. `txd` is 1 whenever `busy`=0.

Source files
------------

// File: rtl/bcd_uart_pkg.sv
// Shared types, ASCII constants and helper functions for the BCD-to-UART reporter.
package bcd_uart_pkg;

  // Frame-level sequencing: idle, one-cycle digit search, characters on the line.
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_LOAD = 2'd1,
    F_SEND = 2'd2
  } frame_state_t;

  // Bit-level sequencing inside the byte serializer.
  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Eight digits plus CR and LF.
  localparam int MAX_CHARS = 10;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Decimal digit to ASCII; nibbles above 9 become '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib <= 4'd9) c = ASCII_ZERO + {4'd0, nib};
    else             c = ASCII_QMARK;
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. ready marks the last cycle of the stop bit;
// a load in that same cycle starts the next byte with no idle gap.
module uart_tx_byte
  import bcd_uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  bit_state_t    state;
  bit_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == LAST);

  // Next bit-phase and end-of-byte indication.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      B_IDLE: begin
        if (load) state_nxt = B_START;
        else      state_nxt = B_IDLE;
      end
      B_START: begin
        if (bit_end) state_nxt = B_DATA;
        else         state_nxt = B_START;
      end
      B_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_nxt = B_STOP;
        else                              state_nxt = B_DATA;
      end
      B_STOP: begin
        if (bit_end) begin
          ready = 1'b1;
          if (load) state_nxt = B_START;
          else      state_nxt = B_IDLE;
        end else begin
          state_nxt = B_STOP;
        end
      end
      default: state_nxt = B_IDLE;
    endcase
  end

  // Bit-phase register.
  always_ff @(posedge clk) begin
    if (rst) state <= B_IDLE;
    else     state <= state_nxt;
  end

  // Bit timer, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      txd     <= 1'b1;
    end else begin
      if ((state == B_IDLE) || bit_end) cnt <= '0;
      else                              cnt <= cnt + CW'(1);
      case (state)
        B_IDLE: begin
          if (load) begin
            shreg <= data;
            txd   <= 1'b0;
          end
        end
        B_START: begin
          if (bit_end) begin
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
          end
        end
        B_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              txd <= 1'b1;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        B_STOP: begin
          if (bit_end && load) begin
            shreg <= data;
            txd   <= 1'b0;
          end
        end
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bcd_uart_tx.sv
// Sends a packed-BCD word as an ASCII decimal line ending in CR LF over a UART.
module bcd_uart_tx
  import bcd_uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CCW = $clog2(MAX_CHARS + 1);

  frame_state_t   state;
  frame_state_t   state_nxt;
  logic [31:0]    bcd_reg;
  logic [2:0]     digit_idx;
  logic [2:0]     first_idx;
  logic [CCW-1:0] char_cnt;
  logic [CCW-1:0] char_total;
  logic [7:0]     next_char;
  logic [7:0]     ser_data;
  logic           ser_load;
  logic           ser_ready;
  logic           frame_end;

  assign frame_end = (char_cnt == char_total);

  // Index of the first digit to send; invalid nibbles count as nonzero.
  always_comb begin
    first_idx = 3'd0;
    if (SUPPRESS_ZEROS) begin
      for (int i = 0; i < 8; i++) begin
        first_idx = (bcd_reg[i*4 +: 4] != 4'd0) ? 3'(i) : first_idx;
      end
    end else begin
      first_idx = 3'd7;
    end
  end

  // Character following the one on the line: remaining digits, then CR, then LF.
  always_comb begin
    if (char_cnt == (char_total - CCW'(2)))      next_char = ASCII_CR;
    else if (char_cnt == (char_total - CCW'(1))) next_char = ASCII_LF;
    else                                         next_char = digit_char(bcd_reg[{digit_idx, 2'b00} +: 4]);
  end

  // Frame sequencing and serializer hand-off.
  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    ser_data  = next_char;
    case (state)
      F_IDLE: begin
        if (start) state_nxt = F_LOAD;
        else       state_nxt = F_IDLE;
      end
      F_LOAD: begin
        ser_load  = 1'b1;
        ser_data  = digit_char(bcd_reg[{first_idx, 2'b00} +: 4]);
        state_nxt = F_SEND;
      end
      F_SEND: begin
        if (ser_ready) begin
          if (frame_end) begin
            state_nxt = F_IDLE;
          end else begin
            ser_load  = 1'b1;
            state_nxt = F_SEND;
          end
        end else begin
          state_nxt = F_SEND;
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= F_IDLE;
    else     state <= state_nxt;
  end

  // Captured word, digit/character counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg    <= 32'd0;
      digit_idx  <= 3'd0;
      char_cnt   <= '0;
      char_total <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        F_IDLE: begin
          if (start) begin
            bcd_reg <= bcd;
            busy    <= 1'b1;
          end
        end
        F_LOAD: begin
          digit_idx  <= first_idx - 3'd1;
          char_cnt   <= CCW'(1);
          char_total <= CCW'(first_idx) + CCW'(3);
        end
        F_SEND: begin
          if (ser_ready) begin
            if (frame_end) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              char_cnt  <= char_cnt + CCW'(1);
              digit_idx <= digit_idx - 3'd1;
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_byte (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .data  (ser_data),
    .ready (ser_ready),
    .txd   (txd)
  );

endmodule
